// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: default geometry,
// FSM state encoding and the access legality check.
package dmem_responder_pkg;

  localparam int unsigned LENGTH_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_e;

  // Word-misaligned or beyond the 2**addr_w word array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: synchronous byte-enabled write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [LENGTH/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [LENGTH-1:0]     wdata_i,
  output logic [LENGTH-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [LENGTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < LENGTH/8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling load/store responder in front of the data array:
// valid/ready request channel, LATENCY wait states, held response channel.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LENGTH  = LENGTH_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [LENGTH-1:0]   req_wdata,
  input  logic [LENGTH/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [LENGTH-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned NBE = LENGTH/8;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmr_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [LENGTH-1:0] wdata_q, wdata_d;
  logic [NBE-1:0]    be_q, be_d;
  logic [LENGTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              commit;
  logic              c_we, c_err;
  logic [31:0]       c_addr;
  logic [LENGTH-1:0] c_wdata, arr_rdata;
  logic [NBE-1:0]    c_be;

  // With zero latency the commit uses the live request, since it shares the acceptance edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;

    case (state_q)
      DMR_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
            state_d = DMR_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = DMR_WAIT;
          end
        end
      end
      DMR_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = DMR_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMR_RESP: begin
        if (rsp_ready) state_d = DMR_IDLE;
      end
      default: state_d = DMR_IDLE;
    endcase

    c_err = addr_err(c_addr, ADDR_W);
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_we || c_err) ? '0 : arr_rdata;
    end
  end

  dmem_array #(
    .LENGTH (LENGTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (commit && c_we && !c_err),
    .be_i    (c_be),
    .addr_i  (c_addr[ADDR_W+1:2]),
    .wdata_i (c_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMR_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == DMR_IDLE);
  assign rsp_valid = (state_q == DMR_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port: accepts one load/store request at a time over a valid/ready channel, models a configurable access latency, and returns read data or a write acknowledgement over a held response channel. Sits between the EXE/MEM register and the word-addressed data array, replacing the zero-latency combinational data memory so the pipeline can be stalled on real wait states.

## Interface
- LENGTH, 32 (`LENGTH): data word width; byte lanes = LENGTH/8.
- ADDR_W, 10 (`DATA_MEM_ADDRESS): word-index width; DEPTH = 2**ADDR_W words.
- LATENCY, 2: wait-state cycles between acceptance and response; 0..15 legal.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  LENGTH  store data.
- req_be  in  LENGTH/8  store byte enables; ignored on loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator consumes response.
- rsp_rdata  out  LENGTH  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch we/addr/wdata/be; go WAIT if LATENCY>0 with counter=LATENCY-1, else RESP directly (commit in same edge as acceptance).
- WAIT: counter decrements each cycle; at counter==0 commit and go RESP.
- Commit (one edge): error check; store writes enabled bytes of word addr[ADDR_W+1:2]; load registers word into rsp_rdata.
- Error: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 -> rsp_err=1, no array write, rsp_rdata=0.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on rsp_valid&rsp_ready go IDLE.
- Store with req_be=0: no bytes change, normal ack, rsp_err=0.
- Array contents not reset; undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Acceptance in cycle N -> rsp_valid first high in cycle N+1+LATENCY.
- rsp_ready already high when rsp_valid rises -> one-cycle response, req_ready high in next cycle; throughput one transaction per LATENCY+2 cycles.
- req_valid while not in IDLE is ignored (not queued); initiator must hold request until req_ready.
- Response back-pressure: RESP held indefinitely; no new request accepted.
- Load after store to same word returns stored data (commit precedes next acceptance).
- Reset asserted mid-transaction: returns to IDLE immediately; store not yet committed is dropped; committed store persists.
- req_ready and rsp_valid are pure functions of state (no combinational path from inputs).

## Structure
- `LENGTH, `DATA_MEM_ADDRESS and state encodings (`DMR_IDLE/`DMR_WAIT/`DMR_RESP, 2 bits) belong in head.v.
- One sub-module: dmem_array (synchronous byte-enabled write, asynchronous read, DEPTH x LENGTH); FSM, counter and response registers in dmem_responder.

## Test plan
- Reset then store addr 0x10, wdata 0xDEADBEEF, be 4'hF, LATENCY=2 -> rsp_valid in cycle N+3, rsp_err=0; load 0x10 -> rsp_rdata 0xDEADBEEF.
- Store 0x10 wdata 0x00000055 be 4'h1 over 0xDEADBEEF -> load returns 0xDEADBE55.
- Load addr 0x13 and load addr 0x1000 (ADDR_W=10) -> rsp_err=1, rsp_rdata=0; array unchanged.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, second req_valid ignored; on rsp_ready=1 returns IDLE next cycle.
- LATENCY=0, back-to-back loads with rsp_ready tied 1 -> rsp_valid in cycle after each acceptance, one transaction per 2 cycles.
- Assert rst during WAIT of store to 0x20 -> outputs at reset values, load 0x20 afterward returns prior contents.
